// File: rtl/input_act_feeder.sv
// input_act_feeder: buffers wide words from the memory controller in a FIFO,
// then slices them LSB-first into LANES*OUTPUT_WIDTH beats for the MAC array
// over a valid/ready handshake. Supports a programmed beat count or drain mode.
module input_act_feeder #(
  parameter int INPUT_WIDTH  = 32,
  parameter int OUTPUT_WIDTH = 8,
  parameter int LANES        = 1,
  parameter int FIFO_DEPTH   = 64,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                            CLK,
  input  logic                            RESETN,
  input  logic                            CLEAR_FIFO,
  input  logic                            START_FEED,
  input  logic [CNT_WIDTH-1:0]            FEED_COUNT,
  input  logic                            FIFO_WR_CMD,
  input  logic [INPUT_WIDTH-1:0]          FIFO_WR_DATA,
  output logic                            FIFO_FULL,
  output logic                            FIFO_EMPTY,
  output logic [$clog2(FIFO_DEPTH):0]     FIFO_LEVEL,
  output logic [LANES*OUTPUT_WIDTH-1:0]   DATA_OUT,
  output logic                            DATA_VALID,
  input  logic                            DATA_READY,
  output logic                            BUSY,
  output logic                            STALL,
  output logic                            DONE,
  output logic                            OVERFLOW
);

  localparam int BEAT_W = LANES * OUTPUT_WIDTH;
  localparam int BPW    = INPUT_WIDTH / BEAT_W;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int LW     = AW + 1;
  localparam int SW     = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [SW-1:0] LAST_SLICE = SW'(BPW - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FEED, S_FIN} state_t;

  state_t                 r_state, w_next;
  logic                   r_start_d, r_clear_d;
  logic                   w_start_edge, w_clear_edge;
  logic [INPUT_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]          r_wptr, r_rptr;
  logic [LW-1:0]          r_level;
  logic                   r_ovf;
  logic                   w_wr, w_pop;
  logic [INPUT_WIDTH-1:0] r_word;
  logic [SW-1:0]          r_slice;
  logic                   r_wvalid;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic                   r_cnt_mode;
  logic                   w_xfer, w_slice_end, w_last;
  logic [BPW-1:0][BEAT_W-1:0] w_slices;

  // CLEAR beats a same-cycle START so an abort never also launches a feed
  assign w_clear_edge = CLEAR_FIFO & ~r_clear_d;
  assign w_start_edge = START_FEED & ~r_start_d & ~w_clear_edge;

  assign FIFO_LEVEL = r_level;
  assign FIFO_FULL  = (r_level == LW'(FIFO_DEPTH));
  assign FIFO_EMPTY = (r_level == '0);
  assign OVERFLOW   = r_ovf;
  assign BUSY       = (r_state != S_IDLE);

  // a read in the same cycle never makes room for a write
  assign w_wr = FIFO_WR_CMD & ~FIFO_FULL & ~w_clear_edge;

  assign w_slices    = r_word;
  assign DATA_OUT    = w_slices[r_slice];
  assign w_slice_end = (r_slice == LAST_SLICE);
  assign w_xfer      = (r_state == S_FEED) & r_wvalid & DATA_READY;

  // previous-cycle copies of the control strobes for edge detection
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_start_d <= 1'b0;
      r_clear_d <= 1'b0;
    end else begin
      r_start_d <= START_FEED;
      r_clear_d <= CLEAR_FIFO;
    end
  end

  // FIFO storage; contents are don't-care while the level says empty
  always_ff @(posedge CLK) begin
    if (w_wr) r_mem[r_wptr] <= FIFO_WR_DATA;
  end

  // FIFO pointers, level and sticky overflow flag
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else if (w_clear_edge) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
      if (FIFO_WR_CMD && FIFO_FULL) r_ovf <= 1'b1;
    end
  end

  // feed state register
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // next state, FIFO pop (incl. prefetch at word wrap) and handshake outputs
  always_comb begin
    w_next     = r_state;
    w_pop      = 1'b0;
    w_last     = 1'b0;
    DATA_VALID = 1'b0;
    STALL      = 1'b0;
    DONE       = 1'b0;
    case (r_state)
      S_IDLE: if (w_start_edge) w_next = S_LOAD;
      S_LOAD: begin
        if (!FIFO_EMPTY) begin
          w_pop  = 1'b1;
          w_next = S_FEED;
        end else if (!r_cnt_mode) begin
          w_next = S_FIN;
        end
      end
      S_FEED: begin
        DATA_VALID = r_wvalid;
        STALL      = ~r_wvalid & FIFO_EMPTY;
        w_last     = w_xfer & (r_cnt_mode ? (r_cnt == CNT_WIDTH'(1))
                                          : (w_slice_end & FIFO_EMPTY));
        if (w_last)
          w_next = S_FIN;
        else if ((~r_wvalid | (w_xfer & w_slice_end)) & ~FIFO_EMPTY)
          w_pop = 1'b1;
      end
      S_FIN: begin
        DONE   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_clear_edge) begin
      w_next = S_IDLE;
      w_pop  = 1'b0;
      w_last = 1'b0;
    end
  end

  // word register, slice index and beat counter
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_word     <= '0;
      r_slice    <= '0;
      r_wvalid   <= 1'b0;
      r_cnt      <= '0;
      r_cnt_mode <= 1'b0;
    end else if (w_clear_edge) begin
      r_slice  <= '0;
      r_wvalid <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_start_edge) begin
        r_cnt      <= FEED_COUNT;
        r_cnt_mode <= |FEED_COUNT;
      end else if (w_xfer && r_cnt_mode) begin
        r_cnt <= r_cnt - CNT_WIDTH'(1);
      end
      if (w_last) begin
        // count may end mid-word: leftover slices are dropped
        r_wvalid <= 1'b0;
        r_slice  <= '0;
      end else if (w_pop) begin
        r_word   <= r_mem[r_rptr];
        r_slice  <= '0;
        r_wvalid <= 1'b1;
      end else if (w_xfer && w_slice_end) begin
        r_wvalid <= 1'b0;
        r_slice  <= '0;
      end else if (w_xfer) begin
        r_slice <= r_slice + SW'(1);
      end
    end
  end

endmodule

// File: tb/tb_input_act_feeder.sv
// Bench for input_act_feeder: LANES=1 instance for most scenarios, LANES=2
// instance for the two-lane slicing case. Beats are checked by a scoreboard.
module tb_input_act_feeder;
  logic        clk = 1'b0;
  logic        rst_n, rst2_n;
  logic        clear_fifo, start_feed, wr_cmd, ready;
  logic [15:0] feed_count;
  logic [31:0] wr_data;

  logic        full1, empty1, valid1, busy1, stall1, done1, ovf1;
  logic [6:0]  level1;
  logic [7:0]  dout1;
  logic        full2, empty2, valid2, busy2, stall2, done2, ovf2;
  logic [6:0]  level2;
  logic [15:0] dout2;

  int n_chk = 0, n_err = 0;
  int n_done = 0, n_done2 = 0, n_valid = 0;
  int cyc = 0, start_cyc = 0, lat = -1;
  logic prev_valid = 1'b0, prev_start = 1'b0, pend = 1'b0;
  logic [7:0] held;
  logic [7:0]  q1[$];
  logic [15:0] q2[$];

  typedef struct {
    logic [31:0] w0, w1;
    int          nw;
    logic [15:0] cnt;
    int          lvl;
  } vec_t;
  vec_t tbl[5];

  always #5 clk = ~clk;

  input_act_feeder #(.INPUT_WIDTH(32), .OUTPUT_WIDTH(8), .LANES(1),
                     .FIFO_DEPTH(64), .CNT_WIDTH(16)) dut (
    .CLK(clk), .RESETN(rst_n), .CLEAR_FIFO(clear_fifo), .START_FEED(start_feed),
    .FEED_COUNT(feed_count), .FIFO_WR_CMD(wr_cmd), .FIFO_WR_DATA(wr_data),
    .FIFO_FULL(full1), .FIFO_EMPTY(empty1), .FIFO_LEVEL(level1),
    .DATA_OUT(dout1), .DATA_VALID(valid1), .DATA_READY(ready),
    .BUSY(busy1), .STALL(stall1), .DONE(done1), .OVERFLOW(ovf1));

  input_act_feeder #(.INPUT_WIDTH(32), .OUTPUT_WIDTH(8), .LANES(2),
                     .FIFO_DEPTH(64), .CNT_WIDTH(16)) dut2 (
    .CLK(clk), .RESETN(rst2_n), .CLEAR_FIFO(clear_fifo), .START_FEED(start_feed),
    .FEED_COUNT(feed_count), .FIFO_WR_CMD(wr_cmd), .FIFO_WR_DATA(wr_data),
    .FIFO_FULL(full2), .FIFO_EMPTY(empty2), .FIFO_LEVEL(level2),
    .DATA_OUT(dout2), .DATA_VALID(valid2), .DATA_READY(ready),
    .BUSY(busy2), .STALL(stall2), .DONE(done2), .OVERFLOW(ovf2));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h expected %0h", nm, act, exp);
    end
  endtask

  // scoreboard, hold-under-backpressure check, DONE/VALID/latency tracking
  always @(negedge clk) begin
    cyc++;
    if (start_feed && !prev_start) start_cyc = cyc;
    prev_start = start_feed;
    if (pend) begin
      chk("hold_valid", valid1, 1'b1);
      chk("hold_data", dout1, held);
    end
    pend = valid1 & ~ready & ~clear_fifo & rst_n;
    held = dout1;
    if (valid1 && !prev_valid && lat < 0) lat = cyc - start_cyc;
    prev_valid = valid1;
    if (valid1) n_valid++;
    if (done1) n_done++;
    if (done2) n_done2++;
    if (valid1 && ready) begin
      if (q1.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL beat1: unexpected beat %0h, none expected", dout1);
      end else chk("beat1", dout1, q1.pop_front());
    end
    if (valid2 && ready) begin
      if (q2.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL beat2: unexpected beat %0h, none expected", dout2);
      end else chk("beat2", dout2, q2.pop_front());
    end
  end

  // all driving happens 1 time unit after a rising edge
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [31:0] d);
    wr_cmd = 1'b1; wr_data = d; step(); wr_cmd = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_fifo = 1'b1; step(); clear_fifo = 1'b0; step();
  endtask

  task automatic start_pulse();
    start_feed = 1'b1; step(); start_feed = 1'b0;
  endtask

  task automatic wait_done(input int bound, input string nm, input int which);
    int d0; bit seen;
    d0 = (which == 2) ? n_done2 : n_done;
    seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      step();
      if (((which == 2) ? n_done2 : n_done) != d0) begin seen = 1'b1; break; end
    end
    chk(nm, seen, 1'b1);
  endtask

  task automatic wait_q1(input int sz, input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (q1.size() == sz) begin seen = 1'b1; break; end
      step();
    end
    chk(nm, seen, 1'b1);
  endtask

  initial begin
    logic [31:0] w;
    int nb, d0, v0;
    bit seen;
    tbl[0] = '{32'h44332211, 32'h88776655, 2, 16'd0, 0};
    tbl[1] = '{32'hDDCCBBAA, 32'h00000000, 2, 16'd3, 1};
    tbl[2] = '{32'h12345678, 32'h9ABCDEF0, 2, 16'd5, 0};
    tbl[3] = '{32'hCAFEF00D, 32'h00000000, 1, 16'd4, 0};
    tbl[4] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 2, 16'd1, 1};

    rst_n = 1'b0; rst2_n = 1'b0; clear_fifo = 1'b0; start_feed = 1'b0;
    wr_cmd = 1'b0; wr_data = '0; feed_count = '0; ready = 1'b1;
    repeat (3) step();
    chk("rst_valid", valid1, 1'b0);
    chk("rst_busy", busy1, 1'b0);
    chk("rst_empty", empty1, 1'b1);
    chk("rst_level", level1, 7'd0);
    chk("rst_flags", {full1, stall1, done1, ovf1, dout1}, 12'h000);
    chk("rst2_empty", empty2, 1'b1);
    rst_n = 1'b1;
    step();

    // table: write words, feed, check beats, latency, leftover level
    for (int e = 0; e < 5; e++) begin
      pulse_clear();
      for (int k = 0; k < tbl[e].nw; k++) wr(k == 0 ? tbl[e].w0 : tbl[e].w1);
      nb = (tbl[e].cnt == 0) ? tbl[e].nw * 4 : int'(tbl[e].cnt);
      for (int k = 0; k < nb; k++) begin
        w = (k < 4) ? tbl[e].w0 : tbl[e].w1;
        q1.push_back(8'(w >> (8 * (k % 4))));
      end
      feed_count = tbl[e].cnt; ready = 1'b1; lat = -1;
      start_pulse();
      wait_done(40, "tbl_done", 1);
      chk("tbl_latency", lat, 2);
      chk("tbl_drained", q1.size(), 0);
      chk("tbl_level", level1, tbl[e].lvl);
      chk("tbl_idle", busy1, 1'b0);
    end

    // two lanes: count ends mid-word, partial word discarded
    rst_n = 1'b0; rst2_n = 1'b1; step();
    wr(32'hDDCCBBAA); wr(32'h00000000);
    q2.push_back(16'hBBAA); q2.push_back(16'hDDCC); q2.push_back(16'h0000);
    feed_count = 16'd3; ready = 1'b1;
    start_pulse();
    wait_done(40, "l2_done", 2);
    chk("l2_drained", q2.size(), 0);
    chk("l2_level", level2, 7'd0);
    rst2_n = 1'b0; rst_n = 1'b1; step();

    // READY pattern 1,0,0,1: monitor checks hold and ordering
    pulse_clear();
    wr(32'h04030201); wr(32'h08070605);
    for (int k = 1; k <= 8; k++) q1.push_back(8'(k));
    feed_count = 16'd0; ready = 1'b1;
    start_pulse();
    d0 = n_done; seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      ready = (i % 4 == 1 || i % 4 == 2) ? 1'b0 : 1'b1;
      step();
      if (n_done != d0) begin seen = 1'b1; break; end
    end
    ready = 1'b1;
    chk("bp_done", seen, 1'b1);
    chk("bp_drained", q1.size(), 0);

    // count 8 with one word: stall at word boundary, resume on write
    pulse_clear();
    wr(32'h11223344);
    q1.push_back(8'h44); q1.push_back(8'h33); q1.push_back(8'h22); q1.push_back(8'h11);
    q1.push_back(8'h88); q1.push_back(8'h77); q1.push_back(8'h66); q1.push_back(8'h55);
    feed_count = 16'd8;
    start_pulse();
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (stall1) begin seen = 1'b1; break; end
    end
    chk("stall_seen", seen, 1'b1);
    chk("stall_valid", valid1, 1'b0);
    chk("stall_beats", q1.size(), 4);
    chk("stall_busy", busy1, 1'b1);
    wr(32'h55667788);
    wait_done(40, "stall_done", 1);
    chk("stall_drained", q1.size(), 0);
    chk("stall_level", level1, 7'd0);

    // fill to full, overflow, then clear
    pulse_clear();
    for (int i = 0; i < 64; i++) wr(32'(i));
    chk("full_flag", full1, 1'b1);
    chk("full_level", level1, 7'd64);
    chk("full_noovf", ovf1, 1'b0);
    wr(32'hDEADBEEF);
    chk("ovf_flag", ovf1, 1'b1);
    chk("ovf_level", level1, 7'd64);
    clear_fifo = 1'b1; step(); clear_fifo = 1'b0;
    chk("clr_level", level1, 7'd0);
    chk("clr_empty", empty1, 1'b1);
    chk("clr_ovf", ovf1, 1'b0);
    step();

    // CLEAR mid-feed: abort, no DONE
    wr(32'h44332211); wr(32'h88776655);
    for (int k = 1; k <= 8; k++) q1.push_back(8'(k * 8'h11));
    feed_count = 16'd0; ready = 1'b1;
    start_pulse();
    wait_q1(5, "clrmid_progress");
    d0 = n_done;
    ready = 1'b0; clear_fifo = 1'b1; step(); clear_fifo = 1'b0;
    chk("clrmid_valid", valid1, 1'b0);
    chk("clrmid_busy", busy1, 1'b0);
    chk("clrmid_level", level1, 7'd0);
    chk("clrmid_left", q1.size(), 5);
    q1.delete();
    ready = 1'b1;
    repeat (5) step();
    chk("clrmid_nodone", n_done - d0, 0);

    // reset mid-feed: abort, no DONE
    wr(32'h44332211); wr(32'h88776655);
    for (int k = 1; k <= 8; k++) q1.push_back(8'(k * 8'h11));
    start_pulse();
    wait_q1(6, "rstmid_progress");
    d0 = n_done;
    ready = 1'b0; rst_n = 1'b0; #1;
    chk("rstmid_valid", valid1, 1'b0);
    chk("rstmid_busy", busy1, 1'b0);
    chk("rstmid_level", level1, 7'd0);
    step(); rst_n = 1'b1; q1.delete(); ready = 1'b1;
    repeat (4) step();
    chk("rstmid_nodone", n_done - d0, 0);

    // drain mode with empty FIFO: DONE only, never VALID
    d0 = n_done; v0 = n_valid;
    feed_count = 16'd0;
    start_pulse();
    repeat (6) step();
    chk("empty_done", n_done - d0, 1);
    chk("empty_novalid", n_valid - v0, 0);
    chk("empty_idle", busy1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
